// File: rtl/ssram_arbiter.sv
// Two-port valid/ready arbiter in front of the ssram controller: one transaction in flight,
// read data steered back to the issuing port, and a bounded wait for read data.
module ssram_arbiter #(
  parameter int          PRIORITY_MODE = 0,
  parameter int          RD_TIMEOUT    = 64,
  parameter logic [7:0]  TIMEOUT_DATA  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] p0_address,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_write,
  input  logic [7:0]  p0_wdata,
  output logic [7:0]  p0_rdata,
  output logic        p0_rdata_en,
  input  logic [18:0] p1_address,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_write,
  input  logic [7:0]  p1_wdata,
  output logic [7:0]  p1_rdata,
  output logic        p1_rdata_en,
  output logic [18:0] address,
  output logic        valid,
  input  logic        ready,
  output logic        write,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        rdata_en,
  output logic        rd_timeout_err
);
  localparam int CW = $clog2(RD_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t        state_reg, state_next;
  logic          owner_reg, owner_next;
  logic          last_grant_reg, last_grant_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [18:0]   address_reg, address_next;
  logic          write_reg, write_next;
  logic [7:0]    wdata_reg, wdata_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;
  logic [7:0]    rdata_reg [2];
  logic [7:0]    rdata_next [2];
  logic [1:0]    rdata_en_reg, rdata_en_next;

  logic [1:0]    req;
  logic [18:0]   req_addr [2];
  logic [1:0]    req_write;
  logic [7:0]    req_wdata [2];
  logic [1:0]    port_ready;
  logic          grant;
  logic          ret_fire;
  logic [7:0]    ret_data;

  assign req          = {p1_valid, p0_valid};
  assign req_addr[0]  = p0_address;
  assign req_addr[1]  = p1_address;
  assign req_write    = {p1_write, p0_write};
  assign req_wdata[0] = p0_wdata;
  assign req_wdata[1] = p1_wdata;

  // Accept is combinational so the requester and ssram complete on the same edge.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign port_ready[gi] = (state_reg == ISSUE) & ready & (owner_reg == 1'(gi));
    end
  endgenerate

  // On contention round-robin favours the port not granted last; mode 1 favours port 0.
  assign grant = (PRIORITY_MODE == 0 && req == 2'b11) ? ~last_grant_reg : ~req[0];

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    address_next    = address_reg;
    write_next      = write_reg;
    wdata_next      = wdata_reg;
    valid_next      = valid_reg;
    err_next        = err_reg;
    rdata_next      = rdata_reg;
    rdata_en_next   = 2'b00;
    ret_fire        = 1'b0;
    ret_data        = rdata;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          address_next    = req_addr[grant];
          write_next      = req_write[grant];
          wdata_next      = req_wdata[grant];
          valid_next      = 1'b1;
          owner_next      = grant;
          last_grant_next = grant;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (ready) begin
          valid_next = 1'b0;
          cnt_next   = '0;
          state_next = write_reg ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        cnt_next = cnt_reg + 1'b1;
        // Real data wins even on the final timeout cycle.
        if (rdata_en) begin
          ret_fire   = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          ret_fire   = 1'b1;
          ret_data   = TIMEOUT_DATA;
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    for (int i = 0; i < 2; i++) begin
      if (ret_fire && owner_reg == 1'(i)) begin
        rdata_next[i]    = ret_data;
        rdata_en_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      cnt_reg        <= '0;
      address_reg    <= '0;
      write_reg      <= 1'b0;
      wdata_reg      <= 8'h00;
      valid_reg      <= 1'b0;
      err_reg        <= 1'b0;
      rdata_reg[0]   <= 8'h00;
      rdata_reg[1]   <= 8'h00;
      rdata_en_reg   <= 2'b00;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      address_reg    <= address_next;
      write_reg      <= write_next;
      wdata_reg      <= wdata_next;
      valid_reg      <= valid_next;
      err_reg        <= err_next;
      rdata_reg[0]   <= rdata_next[0];
      rdata_reg[1]   <= rdata_next[1];
      rdata_en_reg   <= rdata_en_next;
    end
  end

  assign p0_ready       = port_ready[0];
  assign p1_ready       = port_ready[1];
  assign p0_rdata       = rdata_reg[0];
  assign p1_rdata       = rdata_reg[1];
  assign p0_rdata_en    = rdata_en_reg[0];
  assign p1_rdata_en    = rdata_en_reg[1];
  assign address        = address_reg;
  assign valid          = valid_reg;
  assign write          = write_reg;
  assign wdata          = wdata_reg;
  assign rd_timeout_err = err_reg;
endmodule

// File: tb/tb_ssram_arbiter.sv
// Directed bench for ssram_arbiter: a per-cycle vector table plus hand-written
// sequences for arbitration order, read timeout, mid-read reset and timeout precedence.
module tb_ssram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] p0_address, p1_address;
  logic        p0_valid, p1_valid, p0_write, p1_write;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_ready, p1_ready, p0_rdata_en, p1_rdata_en;
  logic [7:0]  p0_rdata, p1_rdata;
  logic [18:0] address;
  logic        valid, write, ready, rdata_en, rd_timeout_err;
  logic [7:0]  wdata, rdata;

  // Second instance in fixed-priority mode, fed the same stimulus.
  logic        pri_p0_ready, pri_p1_ready, pri_p0_rdata_en, pri_p1_rdata_en;
  logic [7:0]  pri_p0_rdata, pri_p1_rdata, pri_wdata;
  logic [18:0] pri_address;
  logic        pri_valid, pri_write, pri_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssram_arbiter #(.PRIORITY_MODE(0), .RD_TIMEOUT(64), .TIMEOUT_DATA(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_write(p0_write),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_rdata_en(p0_rdata_en),
    .p1_address(p1_address), .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_write(p1_write),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_rdata_en(p1_rdata_en),
    .address(address), .valid(valid), .ready(ready), .write(write), .wdata(wdata),
    .rdata(rdata), .rdata_en(rdata_en), .rd_timeout_err(rd_timeout_err)
  );

  ssram_arbiter #(.PRIORITY_MODE(1), .RD_TIMEOUT(64), .TIMEOUT_DATA(8'hFF)) u_pri (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_valid(p0_valid), .p0_ready(pri_p0_ready), .p0_write(p0_write),
    .p0_wdata(p0_wdata), .p0_rdata(pri_p0_rdata), .p0_rdata_en(pri_p0_rdata_en),
    .p1_address(p1_address), .p1_valid(p1_valid), .p1_ready(pri_p1_ready), .p1_write(p1_write),
    .p1_wdata(p1_wdata), .p1_rdata(pri_p1_rdata), .p1_rdata_en(pri_p1_rdata_en),
    .address(pri_address), .valid(pri_valid), .ready(ready), .write(pri_write), .wdata(pri_wdata),
    .rdata(rdata), .rdata_en(rdata_en), .rd_timeout_err(pri_err)
  );

  typedef struct {
    int p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, rdy, rd, ren;
    int ev, ea, ew, ed, p0r, p1r, p0e, p0q, p1e, p1q;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_valid = 0; p0_write = 0; p0_address = '0; p0_wdata = '0;
    p1_valid = 0; p1_write = 0; p1_address = '0; p1_wdata = '0;
    ready = 0; rdata = '0; rdata_en = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Port 0 read; resp_k is the WAIT_RD cycle (1-based) on which ssram returns data, 0 = never.
  task automatic read_p0(input int resp_k, input int data, output int strobe_k,
                         output int strobe_data, output int strobes);
    bit acc = 0;
    strobe_k = -1; strobe_data = -1; strobes = 0;
    p0_valid = 1; p0_write = 0; p0_address = 19'd55; ready = 1;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk); #1;
      acc = p0_ready;
    end
    chk("read_accept", int'(acc), 1);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      p0_valid = 0; ready = 0;
      rdata_en = (k == resp_k); rdata = 8'(data);
      #1;
      if (p0_rdata_en) begin
        strobes++;
        if (strobe_k < 0) begin strobe_k = k; strobe_data = int'(p0_rdata); end
      end
    end
    rdata_en = 0;
    $display("read_p0: resp_k=%0d strobe_k=%0d data=%0d strobes=%0d", resp_k, strobe_k, strobe_data, strobes);
  endtask

  initial begin
    int n, gm[4], gp[4], sk, sd, ns;
    bit found, who;
    // p0v p0w p0a p0d | p1v p1w p1a p1d | rdy rd ren | ev ea ew ed | p0r p1r | p0e p0q p1e p1q
    tbl[0]  = '{1,1,100,123, 0,0,0,0,   0,0,0,     0,0,0,0,       0,0, 0,0,0,0};
    tbl[1]  = '{1,1,100,123, 0,0,0,0,   0,0,0,     1,100,1,123,   0,0, 0,0,0,0};
    tbl[2]  = '{1,1,100,123, 0,0,0,0,   1,0,0,     1,100,1,123,   1,0, 0,0,0,0};
    tbl[3]  = '{0,0,0,0,     0,0,0,0,   0,0,0,     0,100,1,123,   0,0, 0,0,0,0};
    tbl[4]  = '{0,0,0,0,     1,0,200,0, 0,0,0,     0,100,1,123,   0,0, 0,0,0,0};
    tbl[5]  = '{0,0,0,0,     1,0,200,0, 1,0,0,     1,200,0,0,     0,1, 0,0,0,0};
    tbl[6]  = '{0,0,0,0,     0,0,0,0,   0,234,1,   0,200,0,0,     0,0, 0,0,0,0};
    tbl[7]  = '{0,0,0,0,     0,0,0,0,   0,0,0,     0,200,0,0,     0,0, 0,0,1,234};
    tbl[8]  = '{0,0,0,0,     0,0,0,0,   0,0,0,     0,200,0,0,     0,0, 0,0,0,234};
    tbl[9]  = '{1,1,100,123, 0,0,0,0,   0,0,0,     0,200,0,0,     0,0, 0,0,0,234};
    tbl[10] = '{1,1,100,123, 0,0,0,0,   1,0,0,     1,100,1,123,   1,0, 0,0,0,234};
    tbl[11] = '{1,0,100,0,   0,0,0,0,   1,0,0,     0,100,1,123,   0,0, 0,0,0,234};
    tbl[12] = '{1,0,100,0,   0,0,0,0,   1,0,0,     1,100,0,0,     1,0, 0,0,0,234};
    tbl[13] = '{0,0,0,0,     0,0,0,0,   0,123,1,   0,100,0,0,     0,0, 0,0,0,234};
    tbl[14] = '{0,0,0,0,     0,0,0,0,   0,0,0,     0,100,0,0,     0,0, 1,123,0,234};

    reset = 1;
    idle_inputs();
    reset_dut();
    chk("reset_err", int'(rd_timeout_err), 0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      p0_valid = tbl[i].p0v[0]; p0_write = tbl[i].p0w[0];
      p0_address = 19'(tbl[i].p0a); p0_wdata = 8'(tbl[i].p0d);
      p1_valid = tbl[i].p1v[0]; p1_write = tbl[i].p1w[0];
      p1_address = 19'(tbl[i].p1a); p1_wdata = 8'(tbl[i].p1d);
      ready = tbl[i].rdy[0]; rdata = 8'(tbl[i].rd); rdata_en = tbl[i].ren[0];
      #1;
      chk($sformatf("r%0d valid", i), int'(valid), tbl[i].ev);
      chk($sformatf("r%0d address", i), int'(address), tbl[i].ea);
      chk($sformatf("r%0d write", i), int'(write), tbl[i].ew);
      chk($sformatf("r%0d wdata", i), int'(wdata), tbl[i].ed);
      chk($sformatf("r%0d p0_ready", i), int'(p0_ready), tbl[i].p0r);
      chk($sformatf("r%0d p1_ready", i), int'(p1_ready), tbl[i].p1r);
      chk($sformatf("r%0d p0_rdata_en", i), int'(p0_rdata_en), tbl[i].p0e);
      chk($sformatf("r%0d p0_rdata", i), int'(p0_rdata), tbl[i].p0q);
      chk($sformatf("r%0d p1_rdata_en", i), int'(p1_rdata_en), tbl[i].p1e);
      chk($sformatf("r%0d p1_rdata", i), int'(p1_rdata), tbl[i].p1q);
      $display("row %0d: valid=%0d addr=%0d wr=%0d rdy=%0d/%0d en=%0d/%0d", i, valid, address,
               write, p0_ready, p1_ready, p0_rdata_en, p1_rdata_en);
    end

    // Contention: round-robin alternates, fixed priority keeps port 0.
    reset_dut();
    p0_valid = 1; p0_write = 1; p0_address = 19'd1; p0_wdata = 8'd1;
    p1_valid = 1; p1_write = 1; p1_address = 19'd2; p1_wdata = 8'd2;
    ready = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk); #1;
      if (p0_ready || p1_ready) begin
        chk("rr_single_grant", int'(p0_ready & p1_ready), 0);
        gm[n] = int'(p1_ready);
        gp[n] = int'(pri_p1_ready);
        $display("grant %0d: rr_port=%0d pri_port=%0d pri_accept=%0d", n, gm[n], gp[n],
                 pri_p0_ready | pri_p1_ready);
        n++;
      end
    end
    chk("rr_grant_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), gm[i], i % 2);
      chk($sformatf("pri_grant%0d", i), gp[i], 0);
    end
    p0_valid = 0;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      found = pri_p1_ready;
    end
    chk("pri_p1_after_p0_drop", int'(found), 1);
    p1_valid = 0; ready = 0;
    repeat (2) @(negedge clk);

    // Read timeout, then stray rdata_en, then a normal write.
    read_p0(0, 0, sk, sd, ns);
    chk("timeout_cycle", sk, 65);
    chk("timeout_data", sd, 255);
    chk("timeout_strobes", ns, 1);
    chk("timeout_err", int'(rd_timeout_err), 1);
    @(negedge clk); rdata_en = 1; rdata = 8'h55;
    @(negedge clk); rdata_en = 0; #1;
    chk("stray_p0_en", int'(p0_rdata_en), 0);
    chk("stray_p1_en", int'(p1_rdata_en), 0);
    chk("stray_p0_rdata", int'(p0_rdata), 255);
    p1_valid = 1; p1_write = 1; p1_address = 19'd9; p1_wdata = 8'd9; ready = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      found = p1_ready;
      if (found) chk("post_timeout_addr", int'(address), 9);
    end
    chk("post_timeout_write", int'(found), 1);
    @(negedge clk); p1_valid = 0; ready = 0;

    // Reset during WAIT_RD of a port 0 read.
    p0_valid = 1; p0_write = 0; p0_address = 19'd7; ready = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      found = p0_ready;
    end
    chk("rst_read_accept", int'(found), 1);
    @(negedge clk); p0_valid = 0; ready = 0;
    repeat (3) @(negedge clk);
    reset = 1; rdata_en = 1; rdata = 8'h77;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst_valid", int'(valid), 0);
      chk("rst_p0_en", int'(p0_rdata_en), 0);
      chk("rst_err", int'(rd_timeout_err), 0);
      @(negedge clk);
    end
    reset = 0; rdata_en = 0;
    p0_valid = 1; p0_write = 1; p0_address = 19'd300; p0_wdata = 8'd34;
    p1_valid = 1; p1_write = 1; p1_address = 19'd400; p1_wdata = 8'd1;
    ready = 1;
    @(posedge clk); #1;
    chk("post_rst_p0_en", int'(p0_rdata_en), 0);
    found = 0; who = 1;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (p0_ready || p1_ready) begin
        found = 1; who = p1_ready;
        chk("post_rst_addr", int'(address), 300);
        chk("post_rst_wdata", int'(wdata), 34);
        chk("post_rst_write", int'(write), 1);
      end
    end
    chk("post_rst_granted", int'(found), 1);
    chk("post_rst_winner", int'(who), 0);
    $display("post-reset grant: port=%0d addr=%0d wdata=%0d", who, address, wdata);
    @(negedge clk); idle_inputs();
    repeat (2) @(negedge clk);

    // rdata_en on the final timeout cycle returns real data with no error.
    read_p0(64, 8'h3C, sk, sd, ns);
    chk("edge_cycle", sk, 65);
    chk("edge_data", sd, 8'h3C);
    chk("edge_strobes", ns, 1);
    chk("edge_err", int'(rd_timeout_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ssram_arbiter.md
Name: ssram_arbiter

Overview:
Two-port request arbiter that sits directly upstream of the ssram serial-SRAM controller and owns its valid/ready request interface. Port 0 serves the cartridge bus logic and port 1 serves the loader/DMA path. The block serialises both ports onto the single ssram request channel and keeps at most one transaction in flight. It routes read data (rdata/rdata_en) back to the port that issued the read, and guards against a read that never returns with a timeout.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between ports; 1 = port 0 always wins on contention.
RD_TIMEOUT, 64, number of WAIT_RD cycles before a read is aborted (minimum 2).
TIMEOUT_DATA, 8'hFF, data returned to the requester on a read timeout.

Ports:
clk  in  1  system clock; the single clock of the block, same clock as ssram.clk.
reset  in  1  synchronous, active-high reset.
p0_address  in  19  port 0 byte address.
p0_valid  in  1  port 0 request; held with stable fields until p0_ready.
p0_ready  out  1  port 0 accept pulse (combinational).
p0_write  in  1  port 0 direction: 1 = write, 0 = read.
p0_wdata  in  8  port 0 write data.
p0_rdata  out  8  port 0 read data.
p0_rdata_en  out  1  port 0 read-data strobe, one cycle.
p1_address, p1_valid, p1_ready, p1_write, p1_wdata, p1_rdata, p1_rdata_en: same as port 0, for port 1.
address  out  19  to ssram.address.
valid  out  1  to ssram.valid.
ready  in  1  from ssram.ready.
write  out  1  to ssram.write.
wdata  out  8  to ssram.wdata.
rdata  in  8  from ssram.rdata.
rdata_en  in  1  from ssram.rdata_en.
rd_timeout_err  out  1  sticky flag; set on any read timeout; cleared only by reset.

Behaviour:
- Clocking and reset: single clock clk. Reset is synchronous and active-high.
- Reset values: state = IDLE; valid, write, p0/p1_rdata_en and rd_timeout_err = 0; address = 0; wdata, p0_rdata, p1_rdata = 8'h00; last_grant = 1, so port 0 wins the first contention; timeout counter = 0.
- Reset mid-operation: the block returns to IDLE immediately and drops valid. ssram must be reset by the same reset; no handshake completes and no rdata_en is emitted during or after reset for the aborted transaction.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any pN_valid is high, select a winner. PRIORITY_MODE = 0: the port not equal to last_grant wins on contention, otherwise the single requester wins. PRIORITY_MODE = 1: port 0 wins on contention.
  - Register the winner's address/write/wdata into the downstream outputs, set valid = 1, owner = winner, last_grant = winner, then go to ISSUE.
  - Downstream valid rises one cycle after pN_valid is sampled high.
- ISSUE:
  - valid and the downstream fields stay stable while ready = 0.
  - pN_ready = (state == ISSUE) & ready & (owner == N), combinational, so the requester sees accept on the same edge ssram accepts.
  - On ready: valid <= 0. A write goes to IDLE; a read goes to WAIT_RD with the counter cleared.
  - A non-owner port's valid is ignored in ISSUE and stays pending.
- WAIT_RD:
  - The counter increments each cycle.
  - On rdata_en: p<owner>_rdata <= rdata, p<owner>_rdata_en <= 1 for exactly one cycle (one-cycle registered latency), then go to IDLE.
  - If the counter reaches RD_TIMEOUT-1 without rdata_en: p<owner>_rdata <= TIMEOUT_DATA, p<owner>_rdata_en <= 1, rd_timeout_err <= 1, then go to IDLE.
  - rdata_en on the timeout cycle takes precedence: the real data is returned and no error is flagged.
- rdata_en received in IDLE or ISSUE is a stray (for example a late read after a timeout) and is ignored.
- The non-owner port's rdata/rdata_en never change; pN_rdata holds its last value between strobes.
- Only one transaction is outstanding at a time. A new grant can occur in the cycle after a write accept, or in the cycle after the read-data strobe is registered.
- Requester rule: pN_valid must be dropped, or a new request presented, on the edge where pN_ready is high. A request held high after accept is treated as a new request.
- Starvation: in PRIORITY_MODE = 0, two continuously requesting ports strictly alternate grants.

Test Plan:
1. Port 0 write addr 100 data 123, port 1 idle -> valid rises 1 cycle after p0_valid with address = 100, write = 1, wdata = 123; p0_ready pulses on the ssram ready cycle; state returns to IDLE; p1_ready stays 0.
2. Port 1 read addr 200 where the ssram model returns 234 -> p1_rdata_en pulses once, one cycle after rdata_en, with p1_rdata = 234; p0_rdata_en stays 0; p0_rdata is unchanged.
3. p0 and p1 assert valid in the same cycle, both writes, PRIORITY_MODE = 0 -> grant order p0, p1, p0, p1 over 4 continuous requests. With PRIORITY_MODE = 1 and p0 requesting continuously -> p1 is never granted until p0 drops valid.
4. Read where the model withholds rdata_en, RD_TIMEOUT = 64 -> the requester gets rdata_en with data 8'hFF on the 64th WAIT_RD cycle and rd_timeout_err = 1. A later stray rdata_en is ignored, and the next write proceeds normally.
5. Reset asserted during WAIT_RD of a port 0 read -> valid = 0, no p0_rdata_en, rd_timeout_err = 0. After release, a write to addr 300 data 34 is granted port 0 first, with p1 also requesting.
6. Back-to-back write (100, 123) then read (100) from port 0, ssram model loopback -> p0_rdata = 123, and the second request is issued no earlier than one cycle after the first ready.
